// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: cycles active-low anodes over NUM_DIGITS digits
// with a dwell/guard timebase, frame-synchronous value loading and leading-zero blanking.
module display_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DWELL      = 50000,
    parameter int unsigned GUARD      = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    iEn,
    input  logic [4*NUM_DIGITS-1:0] iValue,
    input  logic                    iLoad,
    input  logic [NUM_DIGITS-1:0]   iDp,
    input  logic                    iLzb,
    output logic [3:0]              oBCD,
    output logic [NUM_DIGITS-1:0]   oAn,
    output logic                    oDp,
    output logic                    oBlank,
    output logic                    oFrame
);

    localparam int unsigned NW   = 4 * NUM_DIGITS;
    localparam int unsigned IW   = $clog2(NUM_DIGITS);
    localparam int unsigned CMAX = (DWELL > GUARD) ? DWELL : GUARD;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD > 0) ? GUARD - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GUARD,
        S_SHOW
    } state_e;

    // With no guard interval, digits follow each other directly in SHOW.
    localparam state_e POST_SHOW = (GUARD == 0) ? S_SHOW : S_GUARD;

    state_e                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NW-1:0]           disp_q, disp_d;
    logic [NUM_DIGITS-1:0]   dpr_q, dpr_d;
    logic [NW-1:0]           shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   shdp_q, shdp_d;
    logic                    pend_q, pend_d;
    logic [3:0]              bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    dp_q, dp_d;
    logic                    blank_q, blank_d;
    logic                    frame_q, frame_d;
    logic                    xfer;

    // Digit k>0 is a leading zero when it and every more significant nibble are 0 and its DP is off.
    function automatic logic lz_blank(input logic [NW-1:0] v, input logic [NUM_DIGITS-1:0] dp,
                                      input logic [IW-1:0] k);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (IW'(i) >= k && v[4*i +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
        return (k != '0) && upper_zero && !dp[k];
    endfunction

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        disp_d   = disp_q;
        dpr_d    = dpr_q;
        shadow_d = shadow_q;
        shdp_d   = shdp_q;
        pend_d   = pend_q;
        xfer     = 1'b0;
        frame_d  = 1'b0;
        an_d     = '1;
        bcd_d    = 4'd0;
        dp_d     = 1'b0;
        blank_d  = 1'b1;

        if (!iEn) begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    xfer    = 1'b1;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = POST_SHOW;
                end
                S_GUARD: begin
                    if (cnt_q == GUARD_LAST) begin
                        state_d = S_SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_SHOW: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d = POST_SHOW;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d   = '0;
                            frame_d = 1'b1;
                            xfer    = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Transfer uses the old shadow; a coincident load lands in the shadow for the next frame.
        if (xfer && pend_q) begin
            disp_d = shadow_q;
            dpr_d  = shdp_q;
            pend_d = 1'b0;
        end
        if (iLoad) begin
            shadow_d = iValue;
            shdp_d   = iDp;
            pend_d   = 1'b1;
        end

        if (state_d == S_SHOW && !(iLzb && lz_blank(disp_d, dpr_d, idx_d))) begin
            an_d[idx_d] = 1'b0;
            bcd_d       = disp_d[{idx_d, 2'b00} +: 4];
            dp_d        = dpr_d[idx_d];
            blank_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            disp_q   <= '0;
            dpr_q    <= '0;
            shadow_q <= '0;
            shdp_q   <= '0;
            pend_q   <= 1'b0;
            bcd_q    <= 4'd0;
            an_q     <= '1;
            dp_q     <= 1'b0;
            blank_q  <= 1'b1;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            disp_q   <= disp_d;
            dpr_q    <= dpr_d;
            shadow_q <= shadow_d;
            shdp_q   <= shdp_d;
            pend_q   <= pend_d;
            bcd_q    <= bcd_d;
            an_q     <= an_d;
            dp_q     <= dp_d;
            blank_q  <= blank_d;
            frame_q  <= frame_d;
        end
    end

    assign oBCD   = bcd_q;
    assign oAn    = an_q;
    assign oDp    = dp_q;
    assign oBlank = blank_q;
    assign oFrame = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: a cycle-by-cycle vector table on a GUARD=1 build,
// plus hand sequences for enable drop, async reset and a GUARD=0 build.
module tb_display_scan_ctrl;

    logic        clk, rst, iEn, iLoad, iLzb;
    logic [15:0] iValue;
    logic [3:0]  iDp;
    logic [3:0]  bcd1, an1, bcd0, an0;
    logic        dp1, blank1, frame1, dp0, blank0, frame0;
    logic [10:0] out1, out0;
    int          n_cmp, n_err;

    localparam logic [10:0] DARK = {4'hF, 4'h0, 1'b0, 1'b1, 1'b0};

    display_scan_ctrl #(.NUM_DIGITS(4), .DWELL(4), .GUARD(1)) dut_g1 (
        .clk(clk), .rst(rst), .iEn(iEn), .iValue(iValue), .iLoad(iLoad), .iDp(iDp), .iLzb(iLzb),
        .oBCD(bcd1), .oAn(an1), .oDp(dp1), .oBlank(blank1), .oFrame(frame1)
    );

    display_scan_ctrl #(.NUM_DIGITS(4), .DWELL(4), .GUARD(0)) dut_g0 (
        .clk(clk), .rst(rst), .iEn(iEn), .iValue(iValue), .iLoad(iLoad), .iDp(iDp), .iLzb(iLzb),
        .oBCD(bcd0), .oAn(an0), .oDp(dp0), .oBlank(blank0), .oFrame(frame0)
    );

    assign out1 = {an1, bcd1, dp1, blank1, frame1};
    assign out0 = {an0, bcd0, dp0, blank0, frame0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        ld;
        logic [15:0] val;
        logic [3:0]  dp;
        logic        lzb;
        logic [10:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic        g_en, g_ld, g_lzb;
    logic [15:0] g_val;
    logic [3:0]  g_dp;

    task automatic push(input logic [3:0] an, input logic [3:0] bcd, input logic dpo,
                        input logic blank, input logic frame);
        vec_t v;
        v.en  = g_en;
        v.ld  = g_ld;
        v.val = g_val;
        v.dp  = g_dp;
        v.lzb = g_lzb;
        v.exp = {an, bcd, dpo, blank, frame};
        tbl.push_back(v);
        g_ld = 1'b0;
    endtask

    // Four dwell cycles of one digit; an=F means the slot is blanked.
    task automatic digit(input logic [3:0] an, input logic [3:0] bcd, input logic dpo);
        for (int i = 0; i < 4; i++)
            push(an, (an == 4'hF) ? 4'h0 : bcd, (an == 4'hF) ? 1'b0 : dpo, an == 4'hF, 1'b0);
    endtask

    task automatic gap(input logic frame);
        push(4'hF, 4'h0, 1'b0, 1'b1, frame);
    endtask

    task automatic ld_next(input logic [15:0] v, input logic [3:0] d);
        g_ld  = 1'b1;
        g_val = v;
        g_dp  = d;
    endtask

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got an=%b bcd=%h dp=%b blank=%b frame=%b, want an=%b bcd=%h dp=%b blank=%b frame=%b",
                     name, got[10:7], got[6:3], got[2], got[1], got[0],
                     want[10:7], want[6:3], want[2], want[1], want[0]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; iEn = 1'b0; iLoad = 1'b0; iLzb = 1'b0; iDp = 4'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic build_table();
        g_en = 1'b0; g_ld = 1'b0; g_lzb = 1'b0; g_val = 16'h0; g_dp = 4'h0;
        ld_next(16'h1234, 4'h0); gap(1'b0);
        g_en = 1'b1; gap(1'b0);
        // frame 1: 1234, mid-frame load of 5678
        digit(4'hE, 4'h4, 1'b0); gap(1'b0);
        ld_next(16'h5678, 4'h0);
        digit(4'hD, 4'h3, 1'b0); gap(1'b0);
        digit(4'hB, 4'h2, 1'b0); gap(1'b0);
        digit(4'h7, 4'h1, 1'b0); gap(1'b1);
        // frame 2: 5678, two loads -> newest wins
        digit(4'hE, 4'h8, 1'b0); gap(1'b0);
        ld_next(16'h1111, 4'h0);
        digit(4'hD, 4'h7, 1'b0); gap(1'b0);
        ld_next(16'h2222, 4'h0);
        digit(4'hB, 4'h6, 1'b0); gap(1'b0);
        digit(4'h7, 4'h5, 1'b0); gap(1'b1);
        // frame 3: 2222, load 4321 then a load coincident with the transfer
        digit(4'hE, 4'h2, 1'b0); gap(1'b0);
        digit(4'hD, 4'h2, 1'b0); gap(1'b0);
        ld_next(16'h4321, 4'h0);
        digit(4'hB, 4'h2, 1'b0); gap(1'b0);
        digit(4'h7, 4'h2, 1'b0);
        ld_next(16'h8888, 4'h0); gap(1'b1);
        // frame 4: old shadow 4321 was transferred
        digit(4'hE, 4'h1, 1'b0); gap(1'b0);
        digit(4'hD, 4'h2, 1'b0); gap(1'b0);
        digit(4'hB, 4'h3, 1'b0); gap(1'b0);
        digit(4'h7, 4'h4, 1'b0); gap(1'b1);
        // frame 5: pending 8888 survived; enable blanking, load 0070
        g_lzb = 1'b1;
        digit(4'hE, 4'h8, 1'b0); gap(1'b0);
        ld_next(16'h0070, 4'h0);
        digit(4'hD, 4'h8, 1'b0); gap(1'b0);
        digit(4'hB, 4'h8, 1'b0); gap(1'b0);
        digit(4'h7, 4'h8, 1'b0); gap(1'b1);
        // frame 6: 0070 with blanking, digits 3 and 2 dark
        digit(4'hE, 4'h0, 1'b0); gap(1'b0);
        ld_next(16'h0070, 4'b0100);
        digit(4'hD, 4'h7, 1'b0); gap(1'b0);
        digit(4'hF, 4'h0, 1'b0); gap(1'b0);
        digit(4'hF, 4'h0, 1'b0); gap(1'b1);
        // frame 7: DP on digit 2 keeps it lit
        digit(4'hE, 4'h0, 1'b0); gap(1'b0);
        digit(4'hD, 4'h7, 1'b0); gap(1'b0);
        digit(4'hB, 4'h0, 1'b1); gap(1'b0);
        digit(4'hF, 4'h0, 1'b0); gap(1'b1);
        // frame 8: blanking off
        g_lzb = 1'b0;
        digit(4'hE, 4'h0, 1'b0); gap(1'b0);
        digit(4'hD, 4'h7, 1'b0); gap(1'b0);
        digit(4'hB, 4'h0, 1'b1); gap(1'b0);
        digit(4'h7, 4'h0, 1'b0); gap(1'b1);
    endtask

    initial begin
        logic        found;
        logic [3:0]  ean;
        logic [3:0]  ebcd;
        logic        efr;
        int          d;
        n_cmp = 0; n_err = 0;
        rst = 1'b1; iEn = 1'b0; iLoad = 1'b0; iLzb = 1'b0; iValue = 16'h0; iDp = 4'h0;

        // Reset and idle
        @(negedge clk);
        @(negedge clk);
        check("reset_g1", out1, DARK);
        check("reset_g0", out0, DARK);
        rst = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            check($sformatf("idle%0d", c), out1, DARK);
        end

        // Vector table on the GUARD=1 build
        build_table();
        for (int i = 0; i < tbl.size(); i++) begin
            iEn = tbl[i].en; iLoad = tbl[i].ld; iValue = tbl[i].val;
            iDp = tbl[i].dp; iLzb = tbl[i].lzb;
            @(negedge clk);
            check($sformatf("vec%0d", i), out1, tbl[i].exp);
        end

        // Enable drop during digit 2, pending load while disabled, re-enable latency
        do_reset();
        iValue = 16'h1234; iLoad = 1'b1; iEn = 1'b1;
        @(negedge clk);
        iLoad = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (an1 == 4'b1011) found = 1'b1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL wait_digit2: got found=%b, want found=1", found);
        end
        @(negedge clk);
        iEn = 1'b0;
        @(negedge clk);
        check("drop_dark", out1, DARK);
        iValue = 16'h9876; iLoad = 1'b1;
        @(negedge clk);
        iLoad = 1'b0;
        check("drop_load", out1, DARK);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("drop_idle%0d", c), out1, DARK);
        end
        iEn = 1'b1;
        @(negedge clk);
        check("reen_guard", out1, DARK);
        @(negedge clk);
        check("reen_lit", out1, {4'hE, 4'h6, 1'b0, 1'b0, 1'b0});

        // Asynchronous reset mid-SHOW
        #2 rst = 1'b1;
        #1;
        check("async_rst_g1", out1, DARK);
        check("async_rst_g0", out0, DARK);
        @(negedge clk);
        rst = 1'b0; iEn = 1'b0;

        // GUARD=0 build: back-to-back digits, 16-cycle frame
        @(negedge clk);
        iValue = 16'h1234; iLoad = 1'b1;
        @(negedge clk);
        iLoad = 1'b0; iEn = 1'b1;
        for (int s = 1; s <= 33; s++) begin
            @(negedge clk);
            d    = ((s - 1) / 4) % 4;
            ean  = ~(4'b0001 << d);
            ebcd = 4'(4 - d);
            efr  = (s == 17) || (s == 33);
            check($sformatf("g0_s%0d", s), out0, {ean, ebcd, 1'b0, 1'b0, efr});
        end
        iEn = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
